// File: rtl/qr_pkg.sv
// Shared types, constants and the Q32.32 -> Q16.16 saturating conversion used
// by the QR back-substitution solver and its divider.
package qr_pkg;
   localparam int DATA_W    = 32;
   localparam int FRAC_BITS = 16;
   localparam int N         = 4;

   typedef logic signed [DATA_W-1:0]   elem_t;
   typedef elem_t [N-1:0]              vec4_t;
   typedef vec4_t [N-1:0]              mat4_t;
   typedef logic signed [2*DATA_W-1:0] acc_t;

   typedef enum logic [2:0] {
      S_IDLE, S_QTY, S_ACC, S_DIV, S_FIN, S_DONE
   } state_t;

   localparam acc_t ELEM_MAX = 64'sd2147483647;
   localparam acc_t ELEM_MIN = -64'sd2147483648;

   function automatic elem_t sat32(input acc_t a);
      acc_t s;
      s = a >>> FRAC_BITS;
      if (s > ELEM_MAX)      return 32'h7FFFFFFF;
      else if (s < ELEM_MIN) return 32'h80000000;
      else                   return s[DATA_W-1:0];
   endfunction
endpackage

// File: rtl/qr_fxp_div.sv
// Sequential sign-magnitude restoring divider: (|num|<<FRAC_BITS)/|den|,
// start cycle + 31 iterations + done cycle = 33 cycles, saturating to +/-0x7FFFFFFF.
module qr_fxp_div
   import qr_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  start,
   input  elem_t num,
   input  elem_t den,
   output logic  busy,
   output logic  done,
   output elem_t quotient,
   output logic  div_by_zero
);
   logic        busy_q, busy_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [30:0] dvd_q, dvd_d;
   logic [30:0] quo_q, quo_d;
   logic [31:0] dsr_q, dsr_d;
   logic        neg_q, neg_d, ovf_q, ovf_d, zero_q, zero_d, dz_q, dz_d;

   logic [31:0] num_mag, den_mag;
   logic [47:0] dvd48;
   logic [32:0] trial;
   logic [30:0] mag;

   always_comb begin
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      quo_d   = quo_q;
      dsr_d   = dsr_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      dz_d    = dz_q;
      num_mag = num[31] ? 32'(-num) : 32'(num);
      den_mag = den[31] ? 32'(-den) : 32'(den);
      dvd48   = {num_mag, 16'b0};
      trial   = {rem_q, dvd_q[30]};
      if (start && !busy_q) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         // Quotients >= 2^31 are caught up front, so only 31 quotient bits remain.
         rem_d  = {15'b0, dvd48[47:31]};
         dvd_d  = dvd48[30:0];
         quo_d  = '0;
         dsr_d  = den_mag;
         neg_d  = num[31] ^ den[31];
         zero_d = (num == '0);
         dz_d   = (den == '0);
         ovf_d  = (den == '0) ? (num != '0)
                              : ({16'b0, dvd48} >= {1'b0, den_mag, 31'b0});
      end else if (busy_q) begin
         if (cnt_q == 5'd31) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 5'd1;
            dvd_d = {dvd_q[29:0], 1'b0};
            if (trial >= {1'b0, dsr_q}) begin
               rem_d = trial[31:0] - dsr_q;
               quo_d = {quo_q[29:0], 1'b1};
            end else begin
               rem_d = trial[31:0];
               quo_d = {quo_q[29:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         dvd_q  <= '0;
         quo_q  <= '0;
         dsr_q  <= '0;
         neg_q  <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         dvd_q  <= dvd_d;
         quo_q  <= quo_d;
         dsr_q  <= dsr_d;
         neg_q  <= neg_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
         dz_q   <= dz_d;
      end
   end

   always_comb begin
      mag = zero_q ? 31'd0 : (ovf_q ? 31'h7FFFFFFF : quo_q);
      quotient = neg_q ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
   end

   assign busy        = busy_q;
   assign done        = busy_q && (cnt_q == 5'd31);
   assign div_by_zero = dz_q;
endmodule

// File: rtl/qr_backsub_solver.sv
// Solves R*x = Q^T*y for a 4x4 system: Q^T*y by MAC, then upward back-substitution.
// Fixed 155-cycle accept-to-out_valid latency.
module qr_backsub_solver
   import qr_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  in_valid,
   output logic  in_ready,
   input  mat4_t q_in,
   input  mat4_t r_in,
   input  vec4_t y_in,
   output logic  out_valid,
   input  logic  out_ready,
   output vec4_t x_out,
   output logic  singular
);
   // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [1:0]      row_q, row_d, j_q, j_d;
   mat4_t           q_q, q_d, r_q, r_d;
   vec4_t           y_q, y_d, xw_q, xw_d, x_out_q, x_out_d;
   acc_t [N-1:0]    z_q, z_d;
   acc_t            acc_q, acc_d, prod;
   logic            sw_q, sw_d, sing_q, sing_d;
   logic [1:0]      mac_k, mac_i;

   logic            div_start, div_busy, div_done, div_dz;
   elem_t           div_quo;

   qr_fxp_div u_div (
      .clk         (clk),
      .reset       (reset),
      .start       (div_start),
      .num         (sat32(acc_q)),
      .den         (r_q[row_q][row_q]),
      .busy        (div_busy),
      .done        (div_done),
      .quotient    (div_quo),
      .div_by_zero (div_dz)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      row_d     = row_q;
      j_d       = j_q;
      q_d       = q_q;
      r_d       = r_q;
      y_d       = y_q;
      z_d       = z_q;
      acc_d     = acc_q;
      xw_d      = xw_q;
      sw_d      = sw_q;
      x_out_d   = x_out_q;
      sing_d    = sing_q;
      div_start = 1'b0;
      mac_k     = cnt_q[3:2];
      mac_i     = cnt_q[1:0];
      prod      = '0;
      case (state_q)
         S_IDLE: if (in_valid) begin
            q_d     = q_in;
            r_d     = r_in;
            y_d     = y_in;
            z_d     = '0;
            acc_d   = '0;
            xw_d    = '0;
            sw_d    = 1'b0;
            cnt_d   = '0;
            state_d = S_QTY;
         end
         S_QTY: begin
            prod       = acc_t'(q_q[mac_i][mac_k]) * acc_t'(y_q[mac_i]);
            z_d[mac_k] = z_q[mac_k] + prod;
            cnt_d      = cnt_q + 4'd1;
            // Row 3 has nothing to subtract, so go straight to its divide.
            if (cnt_q == 4'd15) begin
               row_d   = 2'd3;
               acc_d   = z_d[3];
               state_d = S_DIV;
            end
         end
         S_ACC: begin
            prod  = acc_t'(r_q[row_q][j_q]) * acc_t'(xw_q[j_q]);
            acc_d = acc_q - prod;
            j_d   = j_q + 2'd1;
            if (j_q == 2'd3) state_d = S_DIV;
         end
         S_DIV: begin
            div_start = !div_busy;
            if (div_done) begin
               xw_d[row_q] = div_quo;
               if (div_dz) sw_d = 1'b1;
               if (row_q == 2'd0) begin
                  state_d = S_FIN;
               end else begin
                  row_d   = row_q - 2'd1;
                  j_d     = row_q;
                  acc_d   = z_q[row_q - 2'd1];
                  state_d = S_ACC;
               end
            end
         end
         S_FIN: begin
            x_out_d = xw_q;
            sing_d  = sw_q;
            state_d = S_DONE;
         end
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
         j_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         acc_q   <= '0;
         xw_q    <= '0;
         sw_q    <= 1'b0;
         x_out_q <= '0;
         sing_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         j_q     <= j_d;
         q_q     <= q_d;
         r_q     <= r_d;
         y_q     <= y_d;
         z_q     <= z_d;
         acc_q   <= acc_d;
         xw_q    <= xw_d;
         sw_q    <= sw_d;
         x_out_q <= x_out_d;
         sing_q  <= sing_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign x_out     = x_out_q;
   assign singular  = sing_q;
endmodule

// File: tb/tb_qr_backsub_solver.sv
// Bench for qr_backsub_solver: directed table, randomized runs against a plain
// arithmetic reference model, backpressure and mid-operation reset sequences.
module tb_qr_backsub_solver;
   import qr_pkg::*;

   logic  clk, reset, in_valid, in_ready, out_valid, out_ready, singular;
   mat4_t q_in, r_in;
   vec4_t y_in, x_out;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      mat4_t q;
      mat4_t r;
      vec4_t y;
      vec4_t x;
      bit    sing;
   } case_t;

   case_t tbl[4];

   qr_backsub_solver dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q_in      (q_in),
      .r_in      (r_in),
      .y_in      (y_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out),
      .singular  (singular)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic mat4_t ident();
      mat4_t m = '0;
      for (int i = 0; i < 4; i++) m[i][i] = 32'h10000;
      return m;
   endfunction

   // Reference: z = Q^T y in 64-bit, back-substitute, shift/saturate, integer divide.
   function automatic void model(input mat4_t q, input mat4_t r, input vec4_t y,
                                 output vec4_t x, output bit sing);
      longint z[4];
      longint acc, num, den, mag, dmag, qt;
      x = '0;
      sing = 1'b0;
      for (int k = 0; k < 4; k++) begin
         z[k] = 0;
         for (int i = 0; i < 4; i++)
            z[k] += longint'($signed(q[i][k])) * longint'($signed(y[i]));
      end
      for (int i = 3; i >= 0; i--) begin
         acc = z[i];
         for (int j = i + 1; j < 4; j++)
            acc -= longint'($signed(r[i][j])) * longint'($signed(x[j]));
         num = acc >>> 16;
         if (num > 64'sd2147483647) num = 64'sd2147483647;
         if (num < -64'sd2147483648) num = -64'sd2147483648;
         den = longint'($signed(r[i][i]));
         if (den == 0) begin
            sing = 1'b1;
            x[i] = (num > 0) ? 32'h7FFFFFFF : ((num < 0) ? 32'h80000001 : 32'h0);
         end else begin
            mag  = (num < 0 ? -num : num) * 65536;
            dmag = den < 0 ? -den : den;
            qt   = mag / dmag;
            if (qt > 64'sd2147483647) qt = 64'sd2147483647;
            if ((num < 0) != (den < 0)) qt = -qt;
            x[i] = qt[31:0];
         end
      end
   endfunction

   task automatic accept(input mat4_t q, input mat4_t r, input vec4_t y);
      int n = 0;
      @(negedge clk);
      q_in = q; r_in = r; y_in = y; in_valid = 1'b1;
      while (!in_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_at_accept", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 300) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic check_result(input string tag, input vec4_t x, input bit sing, input int lat);
      check({tag, "_latency"}, lat, 155);
      check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_x%0d", tag, i), x_out[i], x[i]);
      check({tag, "_singular"}, {31'b0, singular}, {31'b0, sing});
   endtask

   task automatic check_release(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
      check({tag, "_out_valid_after"}, {31'b0, out_valid}, 32'd0);
   endtask

   task automatic run_case(input string tag, input case_t c);
      int lat;
      accept(c.q, c.r, c.y);
      wait_out(lat);
      check_result(tag, c.x, c.sing, lat);
      check_release(tag);
   endtask

   function automatic int rnd(input int m);
      return int'($urandom_range(2 * m, 0)) - m;
   endfunction

   initial begin
      int    lat;
      case_t rc;
      mat4_t m;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      q_in = '0; r_in = '0; y_in = '0;

      tbl[0].q = ident();
      tbl[0].r = '0;
      for (int i = 0; i < 4; i++) begin
         tbl[0].r[i][i] = 32'h20000;
         tbl[0].y[i] = (i + 1) * 32'h10000;
         tbl[0].x[i] = (i + 1) * 32'h8000;
      end
      tbl[0].sing = 1'b0;

      tbl[1].q = ident();
      tbl[1].r = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = i; j < 4; j++) tbl[1].r[i][j] = 32'h10000;
         tbl[1].y[i] = (4 - i) * 32'h10000;
         tbl[1].x[i] = 32'h10000;
      end
      tbl[1].sing = 1'b0;

      m = ident();
      m[0][0] = 32'h0; m[0][1] = 32'hFFFF0000;
      m[1][0] = 32'h10000; m[1][1] = 32'h0;
      tbl[2].q = m;
      tbl[2].r = ident();
      for (int i = 0; i < 4; i++) tbl[2].y[i] = (i + 1) * 32'h10000;
      tbl[2].x[0] = 32'h20000; tbl[2].x[1] = 32'hFFFF0000;
      tbl[2].x[2] = 32'h30000; tbl[2].x[3] = 32'h40000;
      tbl[2].sing = 1'b0;

      m = ident();
      m[2][2] = 32'h0;
      tbl[3].q = ident();
      tbl[3].r = m;
      for (int i = 0; i < 4; i++) begin
         tbl[3].y[i] = 32'h10000;
         tbl[3].x[i] = 32'h10000;
      end
      tbl[3].x[2] = 32'h7FFFFFFF;
      tbl[3].sing = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      #1;
      check("reset_in_ready", {31'b0, in_ready}, 32'd1);
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_x_out0", x_out[0], 32'h0);
      check("reset_singular", {31'b0, singular}, 32'd0);

      for (int t = 0; t < 4; t++) run_case($sformatf("table%0d", t), tbl[t]);

      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 4; i++) begin
            rc.y[i] = rnd(32'h30000);
            for (int j = 0; j < 4; j++) begin
               rc.q[i][j] = rnd(32'h20000);
               if (j > i) rc.r[i][j] = rnd(32'h20000);
               else if (j < i) rc.r[i][j] = $urandom;
            end
            rc.r[i][i] = ($urandom_range(7, 0) == 0) ? 32'h0 :
                         ($urandom_range(1, 0) == 1 ? 1 : -1) * int'($urandom_range(32'h40000, 32'h800));
         end
         model(rc.q, rc.r, rc.y, rc.x, rc.sing);
         run_case($sformatf("rand%0d", t), rc);
      end

      // Backpressure: hold the result while a competing operand set is offered.
      out_ready = 1'b0;
      accept(tbl[0].q, tbl[0].r, tbl[0].y);
      wait_out(lat);
      check_result("bp", tbl[0].x, tbl[0].sing, lat);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         q_in = tbl[1].q; r_in = tbl[1].r; y_in = tbl[1].y; in_valid = 1'b1;
         @(posedge clk);
         #1;
         check("bp_hold_x1", x_out[1], tbl[0].x[1]);
         check("bp_hold_x3", x_out[3], tbl[0].x[3]);
         check("bp_hold_singular", {31'b0, singular}, 32'd0);
         check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
         check("bp_hold_out_valid", {31'b0, out_valid}, 32'd1);
      end
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
      check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
      check("bp_release_x_kept", x_out[2], tbl[0].x[2]);
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_out(lat);
      check_result("bp_next", tbl[1].x, tbl[1].sing, lat);
      check_release("bp_next");

      run_case("pre_reset_singular", tbl[3]);

      // Reset while the Q^T*y accumulation is in progress.
      accept(tbl[0].q, tbl[0].r, tbl[0].y);
      repeat (4) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
      check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
      check("midreset_x_out2", x_out[2], 32'h0);
      check("midreset_singular", {31'b0, singular}, 32'd0);
      repeat (200) begin
         @(posedge clk);
         #1;
         if (out_valid) check("midreset_spurious_valid", {31'b0, out_valid}, 32'd0);
      end
      run_case("post_reset", tbl[0]);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
